// File: rtl/stage_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit: one bit per clock, HI/LO write pulse DATA_WIDTH+1 edges after start.
// No queuing: busy holds upstream off while iterating; cancel flushes, and MTHI/MTLO pulse on the next cycle.
module stage_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  reg_hi_write_enable,
  output logic [DATA_WIDTH-1:0] reg_hi_write_data,
  output logic                  reg_lo_write_enable,
  output logic [DATA_WIDTH-1:0] reg_lo_write_data,
  output logic                  div_by_zero
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic            is_div, neg_q, neg_r, b_zero;
  logic [DW-1:0]   mcand;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   rem;
  logic [DW-1:0]   quo;

  logic            accept, mdu_op, signed_op, last;
  logic [DW-1:0]   a_abs, b_abs;
  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] prod_step, prod_res;
  logic [DW:0]     shl;
  logic            qbit;
  logic [DW-1:0]   rem_step, quo_step, q_res, r_res;

  logic            hi_we_nxt, lo_we_nxt, dbz_nxt;
  logic [DW-1:0]   hi_d_nxt, lo_d_nxt;

  assign busy      = (state == BUSY);
  assign accept    = (state != BUSY) && start && !cancel;
  assign mdu_op    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign last      = (state == BUSY) && (count == CW'(DW - 1));
  assign a_abs     = (signed_op && operand_a[DW-1]) ? -operand_a : operand_a;
  assign b_abs     = (signed_op && operand_b[DW-1]) ? -operand_b : operand_b;

  // Shift-add multiply: the multiplier sits in the low half and drains out as the product fills in.
  assign mul_sum   = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step = {mul_sum, prod[DW-1:1]};
  assign prod_res  = neg_q ? -prod_step : prod_step;

  // Restoring divide: the partial remainder stays below the divisor, so the DW-bit difference is exact.
  assign shl       = {rem, quo[DW-1]};
  assign qbit      = (shl >= {1'b0, mcand});
  assign rem_step  = qbit ? (shl[DW-1:0] - mcand) : shl[DW-1:0];
  assign quo_step  = {quo[DW-2:0], qbit};
  assign q_res     = neg_q ? -quo_step : quo_step;
  assign r_res     = neg_r ? -rem_step : rem_step;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: state_nxt = (start && mdu_op) ? BUSY : IDLE;
        BUSY:       state_nxt = last ? DONE : BUSY;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    hi_we_nxt = 1'b0;
    lo_we_nxt = 1'b0;
    dbz_nxt   = 1'b0;
    hi_d_nxt  = '0;
    lo_d_nxt  = '0;
    if (!cancel) begin
      if (state != BUSY && start && op == OP_MTHI) begin
        hi_we_nxt = 1'b1;
        hi_d_nxt  = operand_a;
      end else if (state != BUSY && start && op == OP_MTLO) begin
        lo_we_nxt = 1'b1;
        lo_d_nxt  = operand_a;
      end else if (last) begin
        if (is_div && b_zero) begin
          dbz_nxt = 1'b1;
        end else begin
          hi_we_nxt = 1'b1;
          lo_we_nxt = 1'b1;
          hi_d_nxt  = is_div ? r_res : prod_res[2*DW-1:DW];
          lo_d_nxt  = is_div ? q_res : prod_res[DW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_hi_write_enable <= 1'b0;
      reg_lo_write_enable <= 1'b0;
      reg_hi_write_data   <= '0;
      reg_lo_write_data   <= '0;
      div_by_zero         <= 1'b0;
    end else begin
      reg_hi_write_enable <= hi_we_nxt;
      reg_lo_write_enable <= lo_we_nxt;
      reg_hi_write_data   <= hi_d_nxt;
      reg_lo_write_data   <= lo_d_nxt;
      div_by_zero         <= dbz_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
    end else if (accept && mdu_op) begin
      count  <= '0;
      is_div <= (op == OP_DIV) || (op == OP_DIVU);
      neg_q  <= signed_op && (operand_a[DW-1] ^ operand_b[DW-1]);
      neg_r  <= signed_op && operand_a[DW-1];
      b_zero <= (operand_b == '0);
      if (op == OP_DIV || op == OP_DIVU) begin
        mcand <= b_abs;
        quo   <= a_abs;
        rem   <= '0;
      end else begin
        mcand <= a_abs;
        prod  <= {{DW{1'b0}}, b_abs};
      end
    end else if (state == BUSY) begin
      count <= count + 1'b1;
      if (is_div) begin
        rem <= rem_step;
        quo <= quo_step;
      end else begin
        prod <= prod_step;
      end
    end
  end
endmodule

// File: tb/tb_stage_mdu.sv
// Directed bench for stage_mdu: arithmetic results, latency, MTHI/MTLO, ignored start, cancel and reset abort.
module tb_stage_mdu;
  logic        clock, reset, start, cancel;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, hi_we, lo_we, dbz;
  logic [31:0] hi_d, lo_d;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cnt;
  logic seen;

  stage_mdu #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel), .busy(busy),
    .reg_hi_write_enable(hi_we), .reg_hi_write_data(hi_d),
    .reg_lo_write_enable(lo_we), .reg_lo_write_data(lo_d),
    .div_by_zero(dbz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] flags();
    return 64'({busy, hi_we, lo_we, dbz});
  endfunction

  // Issues one MULT/DIV and stops in the write-pulse cycle; inj>=0 presents a stray MULT start on that busy cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz, input int inj);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    tick();
    start = 1'b0;
    check({tag, ":busy_after_start"}, 64'(busy), 64'd1);
    cnt = 0;
    seen = 1'b0;
    while (busy && cnt < 100) begin
      if (hi_we || lo_we || dbz) seen = 1'b1;
      if (cnt == inj) begin
        start = 1'b1; op = 3'd1; operand_a = 32'd3; operand_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      cnt++;
    end
    start = 1'b0;
    check({tag, ":busy_cycles"}, 64'(cnt), 64'd32);
    check({tag, ":early_pulse"}, 64'(seen), 64'd0);
    check({tag, ":hi_we"}, 64'(hi_we), 64'(!exp_dbz));
    check({tag, ":lo_we"}, 64'(lo_we), 64'(!exp_dbz));
    check({tag, ":hi_data"}, 64'(hi_d), exp_dbz ? 64'd0 : 64'(exp_hi));
    check({tag, ":lo_data"}, 64'(lo_d), exp_dbz ? 64'd0 : 64'(exp_lo));
    check({tag, ":div_by_zero"}, 64'(dbz), 64'(exp_dbz));
  endtask

  task automatic idle_after(input string tag);
    tick();
    check({tag, ":cleared"}, flags(), 64'd0);
    check({tag, ":data_cleared"}, {hi_d, lo_d}, 64'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (hi_we || lo_we || dbz || busy) seen = 1'b1;
    end
    check({tag, ":quiet"}, 64'(seen), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0;
    operand_a = '0; operand_b = '0;
    tick(); tick();
    check("reset:flags", flags(), 64'd0);
    check("reset:data", {hi_d, lo_d}, 64'd0);
    reset = 1'b1;
    tick();

    run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, -1);
    idle_after("multu_max");

    run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1);
    // next op is started in the DONE cycle
    run_op("mult_minmin", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, -1);
    idle_after("mult_minmin");

    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1);
    idle_after("div_neg");

    run_op("divu_stray", 3'd4, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 5);
    idle_after("divu_stray");

    run_op("div_zero", 3'd3, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, -1);
    idle_after("div_zero");

    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, -1);
    idle_after("div_ovf");

    start = 1'b1; op = 3'd5; operand_a = 32'h12345678;
    tick();
    start = 1'b0;
    check("mthi:flags", flags(), 64'b0100);
    check("mthi:hi_data", 64'(hi_d), 64'h12345678);
    idle_after("mthi");

    start = 1'b1; op = 3'd6; operand_a = 32'hCAFEF00D;
    tick();
    start = 1'b0;
    check("mtlo:flags", flags(), 64'b0010);
    check("mtlo:lo_data", 64'(lo_d), 64'hCAFEF00D);
    idle_after("mtlo");

    start = 1'b1; cancel = 1'b1; op = 3'd5; operand_a = 32'h11111111;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_mthi:flags", flags(), 64'd0);

    start = 1'b1; op = 3'd1; operand_a = 32'd5; operand_b = 32'd6;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("cancel_mult:still_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_mult:flags", flags(), 64'd0);
    quiet("cancel_mult", 40);

    start = 1'b1; op = 3'd3; operand_a = 32'd1000; operand_b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check("reset_div:still_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("reset_div:flags", flags(), 64'd0);
    tick();
    reset = 1'b1;
    quiet("reset_div", 40);

    run_op("divu_after_abort", 3'd4, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, -1);
    idle_after("divu_after_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
